// File: rtl/mad_int_pkg.sv
// Shared types and helpers for the MAD interrupt controller.
package mad_int_pkg;

  localparam int unsigned    MaxSrc    = 16;
  localparam logic [15:0]    VecBase   = 16'h0010;
  localparam int unsigned    VecStride = 2;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } prio_t;

  // Lowest set bit wins; sources narrower than MaxSrc are zero-extended by the caller.
  function automatic prio_t prio_first(input logic [MaxSrc-1:0] vec);
    prio_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = MaxSrc - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mad_int_stack.sv
// In-service LIFO of source ids; a simultaneous push and pop replaces the top entry.
module mad_int_stack #(
  parameter int unsigned Entries = 4,
  parameter int unsigned IdW     = 3,
  localparam int unsigned CntW   = $clog2(Entries + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [IdW-1:0]  id_i,
  output logic [IdW-1:0]  top_o,
  output logic [CntW-1:0] depth_o,
  output logic            empty_o
);

  logic [IdW-1:0]  mem_q [Entries];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] wr_idx;
  logic            do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && (do_pop || (cnt_q < CntW'(Entries)));
    wr_idx  = do_pop ? cnt_q - CntW'(1) : cnt_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < Entries; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < Entries; i++) begin
        if (do_push && (wr_idx == CntW'(i))) mem_q[i] <= id_i;
      end
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < Entries; i++) begin
      if (cnt_q == CntW'(i + 1)) top_o = mem_q[i];
    end
  end

  assign depth_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mad_int_ctrl.sv
// Prioritised, nesting interrupt controller with req/ack handshake towards fetch.
module mad_int_ctrl
  import mad_int_pkg::*;
#(
  parameter int unsigned        NUM_SRC    = 8,
  parameter int unsigned        NEST_DEPTH = 4,
  parameter int unsigned        ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(VecBase),
  parameter int unsigned        VEC_STRIDE = VecStride,
  parameter logic [NUM_SRC-1:0] EDGE_MASK  = '1
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic [NUM_SRC-1:0]                Irq,
  input  logic                              MaskWe,
  input  logic [NUM_SRC-1:0]                MaskIn,
  input  logic                              IntAck,
  input  logic                              Rti,
  output logic                              IntReq,
  output logic [ADDR_W-1:0]                 IntVec,
  output logic [NUM_SRC-1:0]                InService,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   Depth,
  output logic                              Err
);

  localparam int unsigned IdW  = $clog2(NUM_SRC);
  localparam int unsigned DepW = $clog2(NEST_DEPTH + 1);

  state_e             state_q, state_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]  vec_q, vec_d;
  logic [NUM_SRC-1:0] irq_q, edge_pend_q, edge_pend_d, mask_q;
  logic               err_q;

  logic [NUM_SRC-1:0] pending, below_top, eligible, ack_clr;
  logic [IdW-1:0]     top_id, win_id;
  logic               stk_empty, push;
  prio_t              prio;

  // Level sources follow the registered line; edge sources use the latched pending bit.
  always_comb begin
    pending = (edge_pend_q & EDGE_MASK) | (irq_q & ~EDGE_MASK);
    for (int i = 0; i < NUM_SRC; i++) begin
      below_top[i] = stk_empty | (IdW'(i) < top_id);
    end
    eligible = pending & ~mask_q & below_top;
    prio     = prio_first(MaxSrc'(eligible));
    win_id   = prio.idx[IdW-1:0];
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (prio.found && (Depth < DepW'(NEST_DEPTH))) begin
          id_d    = win_id;
          vec_d   = VEC_BASE + ADDR_W'(win_id) * ADDR_W'(VEC_STRIDE);
          state_d = StReq;
        end
      end
      StReq: begin
        if (IntAck) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  // A fresh edge in the same cycle as the ack of that source stays pending.
  always_comb begin
    ack_clr     = push ? (NUM_SRC'(1) << id_q) : '0;
    edge_pend_d = ((edge_pend_q & ~ack_clr) | (Irq & ~irq_q)) & EDGE_MASK;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      id_q        <= '0;
      vec_q       <= '0;
      irq_q       <= '0;
      edge_pend_q <= '0;
      mask_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      vec_q       <= vec_d;
      irq_q       <= Irq;
      edge_pend_q <= edge_pend_d;
      err_q       <= Rti && stk_empty;
      if (MaskWe) mask_q <= MaskIn;
    end
  end

  mad_int_stack #(
    .Entries(NEST_DEPTH),
    .IdW    (IdW)
  ) u_stack (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .push_i (push),
    .pop_i  (Rti),
    .id_i   (id_q),
    .top_o  (top_id),
    .depth_o(Depth),
    .empty_o(stk_empty)
  );

  assign IntReq    = (state_q == StReq);
  assign IntVec    = vec_q;
  assign Err       = err_q;
  assign InService = stk_empty ? '0 : (NUM_SRC'(1) << top_id);

endmodule
